// File: rtl/fifo_umbral_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds,
// one instance per virtual channel between the packet source and the channel arbiter.
//
//   state  | meaning
//   RESET  | defaults loaded, no traffic accepted
//   INIT   | flush every cycle, sample and validate thresholds
//   ACTIVE | push/pop serviced against the occupancy count
module fifo_umbral_param #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  umbral_superior,
  input  logic [CNT_W-1:0]  umbral_inferior,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              cfg_error,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SUP_RST = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] INF_RST = CNT_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    sup_q, sup_d;
  logic [CNT_W-1:0]    inf_q, inf_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                cfg_err_q, cfg_err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic ops_en;
  logic cfg_ok;
  logic pop_ok;
  logic push_ok;

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = init ? ST_INIT : ST_ACTIVE;
      ST_INIT:   state_d = init ? ST_INIT : ST_ACTIVE;
      ST_ACTIVE: state_d = init ? ST_INIT : ST_ACTIVE;
      default:   state_d = ST_RESET;
    endcase
  end

  // Traffic is serviced on any non-init edge once out of RESET, so the edge on
  // which init falls already honours push/pop.
  assign ops_en  = !init && (state_q != ST_RESET);
  assign cfg_ok  = (umbral_inferior != '0) &&
                   (umbral_inferior < umbral_superior) &&
                   (umbral_superior <= DEPTH_C);
  assign pop_ok  = ops_en && pop && (count_q != '0);
  assign push_ok = ops_en && push && ((count_q != DEPTH_C) || pop_ok);

  always_comb begin : datapath
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sup_d      = sup_q;
    inf_d      = inf_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    cfg_err_d  = cfg_err_q;

    if (init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (cfg_ok) begin
        sup_d     = umbral_superior;
        inf_d     = umbral_inferior;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (ops_en) begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        data_out_d = mem_q[rd_ptr_q];
        valid_d    = 1'b1;
      end
      if (push && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (pop && (count_q == '0)) begin
        unf_d = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sup_q      <= SUP_RST;
      inf_q      <= INF_RST;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sup_q      <= sup_d;
      inf_q      <= inf_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= sup_q);
  assign almost_empty = (count_q != '0) && (count_q <= inf_q);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign cfg_error    = cfg_err_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_fifo_umbral_param.sv
// Scoreboard bench for fifo_umbral_param: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_fifo_umbral_param;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [CNT_W-1:0]  umbral_superior = '0;
  logic [CNT_W-1:0]  umbral_inferior = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [CNT_W-1:0]  count;
  logic              full, empty, almost_full, almost_empty;
  logic              overflow, underflow, cfg_error;
  logic [1:0]        state_out;

  always #5 clk = ~clk;

  fifo_umbral_param #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .push           (push),
    .pop            (pop),
    .data_in        (data_in),
    .umbral_superior(umbral_superior),
    .umbral_inferior(umbral_inferior),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .overflow       (overflow),
    .underflow      (underflow),
    .cfg_error      (cfg_error),
    .state_out      (state_out)
  );

  typedef struct {
    int              cnt;
    bit              full, empty, af, ae, ovf, unf, cfg, valid;
    int              st;
    logic [DATA_W-1:0] dout;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] rd_exp[$];

  // reference model state
  logic [DATA_W-1:0] m_q[$];
  int                m_sup = DEPTH - 2;
  int                m_inf = 1;
  int                m_st  = 0;
  bit                m_ovf, m_unf, m_cfg, m_valid;
  logic [DATA_W-1:0] m_dout = '0;

  int total = 0;
  int bad   = 0;

  logic [CNT_W-1:0] su_v = 4'd6;
  logic [CNT_W-1:0] il_v = 4'd1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model(bit rst, bit ini, bit ps, bit pp, logic [DATA_W-1:0] din, int su, int il);
    exp_t e;
    int   n;
    if (rst) begin
      m_q.delete();
      m_sup = DEPTH - 2; m_inf = 1; m_st = 0;
      m_ovf = 0; m_unf = 0; m_cfg = 0; m_valid = 0; m_dout = '0;
    end else if (ini) begin
      m_q.delete();
      m_ovf = 0; m_unf = 0; m_valid = 0; m_st = 1;
      if (il >= 1 && il < su && su <= DEPTH) begin
        m_sup = su; m_inf = il; m_cfg = 0;
      end else begin
        m_cfg = 1;
      end
    end else if (m_st == 0) begin
      m_st = 2; m_valid = 0;
    end else begin
      m_st = 2; m_valid = 0;
      n = m_q.size();
      if (pp) begin
        if (n > 0) begin
          m_dout = m_q.pop_front();
          m_valid = 1;
          rd_exp.push_back(m_dout);
        end else begin
          m_unf = 1;
        end
      end
      if (ps) begin
        if (n < DEPTH || (pp && n > 0)) m_q.push_back(din);
        else m_ovf = 1;
      end
    end
    n = m_q.size();
    e.cnt = n; e.full = (n == DEPTH); e.empty = (n == 0);
    e.af = (n >= m_sup); e.ae = (n != 0) && (n <= m_inf);
    e.ovf = m_ovf; e.unf = m_unf; e.cfg = m_cfg; e.valid = m_valid;
    e.st = m_st; e.dout = m_dout;
    exp_q.push_back(e);
  endtask

  task automatic step(bit rst, bit ini, bit ps, bit pp, logic [DATA_W-1:0] din);
    @(negedge clk);
    #1;
    reset = rst; init = ini; push = ps; pop = pp; data_in = din;
    umbral_superior = su_v; umbral_inferior = il_v;
    model(rst, ini, ps, pp, din, int'(su_v), int'(il_v));
  endtask

  task automatic do_push(logic [DATA_W-1:0] d); step(0, 0, 1, 0, d); endtask
  task automatic do_pop();                      step(0, 0, 0, 1, '0); endtask
  task automatic do_init();
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
  endtask

  // monitor: outputs settle after the posedge, compared on the following negedge
  exp_t              mon_e;
  logic [DATA_W-1:0] mon_w;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("state_out",    32'(state_out),    32'(mon_e.st));
        chk("count",        32'(count),        32'(mon_e.cnt));
        chk("full",         32'(full),         32'(mon_e.full));
        chk("empty",        32'(empty),        32'(mon_e.empty));
        chk("almost_full",  32'(almost_full),  32'(mon_e.af));
        chk("almost_empty", 32'(almost_empty), 32'(mon_e.ae));
        chk("overflow",     32'(overflow),     32'(mon_e.ovf));
        chk("underflow",    32'(underflow),    32'(mon_e.unf));
        chk("cfg_error",    32'(cfg_error),    32'(mon_e.cfg));
        chk("valid_out",    32'(valid_out),    32'(mon_e.valid));
        chk("data_out",     32'(data_out),     32'(mon_e.dout));
        if (valid_out === 1'b1) begin
          if (rd_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_word: valid_out high, got %0h expected no word", data_out);
          end else begin
            mon_w = rd_exp.pop_front();
            chk("rd_word", 32'(data_out), 32'(mon_w));
          end
        end
      end
    end
  end

  int r;
  int pb;
  initial begin
    // reset then configure 6/1
    su_v = 4'd6; il_v = 4'd1;
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    do_init();

    // fill past full, drain past empty
    for (int i = 1; i <= 9; i++) do_push(10'(i));
    repeat (11) do_pop();

    // pointer wrap
    for (int i = 0; i < 8; i++) do_push(10'(10'h3F0 + i));
    repeat (4) do_pop();
    for (int i = 0; i < 4; i++) do_push(10'(10'h100 + i));
    repeat (8) do_pop();

    // push+pop at full, drops at full, push+pop at empty
    do_init();
    for (int i = 0; i < 8; i++) do_push(10'($urandom_range(0, 1023)));
    repeat (5) step(0, 0, 1, 1, 10'h155);
    repeat (3) do_push(10'h2AA);
    repeat (8) do_pop();
    step(0, 0, 1, 1, 10'h0AB);
    do_pop();

    // invalid then valid reconfiguration, reset mid-fill
    su_v = 4'd3; il_v = 4'd5;
    do_init();
    for (int i = 0; i < 7; i++) do_push(10'(10'h200 + i));
    su_v = 4'd4; il_v = 4'd2;
    do_init();
    for (int i = 0; i < 5; i++) do_push(10'(10'h300 + i));
    repeat (5) do_pop();
    repeat (3) do_push(10'h0F0);
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 7; i++) do_push(10'(10'h010 + i));
    repeat (7) do_pop();

    // randomized traffic with occasional reconfiguration and reset
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        step(1, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
      end else if (r < 4) begin
        su_v = CNT_W'($urandom_range(0, 15));
        il_v = CNT_W'($urandom_range(0, 15));
        repeat ($urandom_range(1, 2))
          step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
        step(0, 0, 0, 0, '0);
      end else begin
        pb = ((i % 256) < 128) ? 70 : 30;
        step(0, 0, ($urandom_range(0, 99) < pb), ($urandom_range(0, 99) < (100 - pb)),
             10'($urandom_range(0, 1023)));
      end
    end

    step(0, 0, 0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("exp_drain", 32'(exp_q.size()), 32'd0);
    chk("rd_drain",  32'(rd_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
